// File: rtl/apb_modport.sv
// apb_modport: APB master bridge plus two APB slave memories, routed by the address MSB.
// Define APB_WAIT_STATE_EN to make each slave insert one wait state per transfer.
module apb_modport #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          READ_WRITE,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, next;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic pwrite, psel1, psel2, penable, pready;
  logic [1:0] sel, ready;
  logic [DW-1:0] prdata [2];
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = transfer ? SETUP : IDLE;
      SETUP:   next = ACCESS;
      ACCESS:  next = !pready ? ACCESS : transfer ? SETUP : IDLE;
      default: next = IDLE;
    endcase
  end
  // Request is captured only when entering SETUP, so inputs may change freely mid-transfer.
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (next == SETUP) begin
      pwrite <= ~READ_WRITE;
      paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
      pwdata <= apb_write_data;
    end
  assign psel1   = (state != IDLE) & ~paddr[AW-1];
  assign psel2   = (state != IDLE) & paddr[AW-1];
  assign penable = state == ACCESS;
  assign sel     = {psel2, psel1};
  for (genvar s = 0; s < 2; s++) begin : g_slave
    logic [DW-1:0] mem [2**(AW-1)];
`ifdef APB_WAIT_STATE_EN
    logic waited;
    always_ff @(posedge pclk or negedge presetn)
      if (!presetn) waited <= 1'b0;
      else waited <= sel[s] & penable & ~waited;
    assign ready[s] = sel[s] & waited;
`else
    assign ready[s] = sel[s];
`endif
    always_ff @(posedge pclk)
      if (sel[s] & penable & ready[s] & pwrite) mem[paddr[AW-2:0]] <= pwdata;
    assign prdata[s] = sel[s] ? mem[paddr[AW-2:0]] : '0;
  end
  assign pready = |ready;
  // Unselected slave drives zero, so OR-ing picks the selected one.
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) apb_read_data_out <= '0;
    else if (penable & pready & ~pwrite) apb_read_data_out <= prdata[0] | prdata[1];
endmodule

// File: tb/tb_apb_modport.sv
// tb_apb_modport: randomized self-checking bench for apb_modport against a transaction-level memory model.
module tb_apb_modport;
  localparam int AW = 9;
  localparam int DW = 8;
`ifdef APB_WAIT_STATE_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif
  logic pclk = 1'b0, presetn = 1'b0, transfer = 1'b0, READ_WRITE = 1'b0;
  logic [AW-1:0] apb_write_paddr = '0, apb_read_paddr = '0;
  logic [DW-1:0] apb_write_data = '0, apb_read_data_out;
  int checks = 0, errors = 0;
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] ref_out = '0;
  typedef struct {bit rd; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
  op_t ops[$];
  logic [AW-1:0] wlist[$];

  always #5 pclk = ~pclk;

  apb_modport #(.AW(AW), .DW(DW)) dut (
    .pclk(pclk), .presetn(presetn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic scramble(input bit tr);
    transfer        = tr;
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
  endtask

  task automatic drive(input op_t o);
    scramble(1'b1);
    READ_WRITE = o.rd;
    if (o.rd) apb_read_paddr = o.a;
    else begin
      apb_write_paddr = o.a;
      apb_write_data  = o.d;
    end
  endtask

  function automatic logic [31:0] bus(input logic e);
    return 32'({dut.psel2, dut.psel1, e, dut.pwrite, dut.paddr});
  endfunction

  // Runs the queued ops back-to-back; each takes L cycles from its capture edge.
  task automatic run_ops();
    op_t cur;
    @(negedge pclk);
    drive(ops[0]);
    while (ops.size() > 0) begin
      cur = ops.pop_front();
      @(posedge pclk);
      @(negedge pclk);
      check("out_at_setup", 32'(apb_read_data_out), 32'(ref_out));
      check("setup_bus", 32'({dut.psel2, dut.psel1, dut.penable, dut.pwrite, dut.paddr}),
            32'({cur.a[AW-1], ~cur.a[AW-1], 1'b0, ~cur.rd, cur.a}));
      scramble(1'($urandom));
      for (int i = 1; i < L; i++) begin
        @(posedge pclk);
        @(negedge pclk);
        check("access_bus", bus(dut.penable), 32'({cur.a[AW-1], ~cur.a[AW-1], 1'b1, ~cur.rd, cur.a}));
        check("out_in_access", 32'(apb_read_data_out), 32'(ref_out));
        if (i < L - 1) scramble(1'($urandom));
        else if (ops.size() > 0) drive(ops[0]);
        else scramble(1'b0);
      end
      if (cur.rd) ref_out = ref_mem[cur.a];
      else ref_mem[cur.a] = cur.d;
    end
    @(posedge pclk);
    @(negedge pclk);
    check("out_final", 32'(apb_read_data_out), 32'(ref_out));
    check("idle_bus", 32'({dut.psel2, dut.psel1, dut.penable}), 32'(0));
  endtask

  task automatic one(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ops.push_back(op_t'{rd, a, d});
    run_ops();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    op_t o;
    repeat (4) begin
      @(negedge pclk);
      scramble(1'b1);
      check("rst_out", 32'(apb_read_data_out), 32'(0));
      check("rst_bus", 32'({dut.psel2, dut.psel1, dut.penable, dut.pwrite, dut.paddr}), 32'(0));
    end
    @(negedge pclk);
    scramble(1'b0);
    presetn = 1'b1;
    one(1'b0, 9'h012, 8'h3C);
    one(1'b1, 9'h012, 8'h00);
    one(1'b0, 9'h112, 8'hA5);
    one(1'b0, 9'h012, 8'h5A);
    one(1'b1, 9'h112, 8'h00);
    one(1'b1, 9'h012, 8'h00);
    for (int k = 1; k <= 4; k++) ops.push_back(op_t'{1'b0, AW'(k), DW'(k * 17)});
    for (int k = 1; k <= 4; k++) ops.push_back(op_t'{1'b1, AW'(k), DW'(0)});
    run_ops();
    one(1'b0, 9'h020, 8'h77);
    one(1'b1, 9'h020, 8'h00);
    one(1'b0, 9'h005, 8'h5E);
    @(negedge pclk);
    drive(op_t'{1'b0, 9'h005, 8'hA1});
    @(posedge pclk);
    @(negedge pclk);
    scramble(1'b0);
    @(posedge pclk);
    @(negedge pclk);
    check("mid_access", 32'(dut.penable), 32'(1));
    presetn = 1'b0;
    #1;
    check("mid_rst_bus", 32'({dut.psel2, dut.psel1, dut.penable, dut.pwrite, dut.paddr}), 32'(0));
    check("mid_rst_out", 32'(apb_read_data_out), 32'(0));
    ref_out = '0;
    repeat (3) begin
      @(negedge pclk);
      scramble(1'b1);
    end
    @(negedge pclk);
    scramble(1'b0);
    presetn = 1'b1;
    one(1'b1, 9'h005, 8'h00);
    for (int b = 0; b < 20; b++) begin
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        o.rd = (wlist.size() > 0) && ($urandom_range(0, 1) == 1);
        if (o.rd) begin
          o.a = wlist[$urandom_range(0, wlist.size() - 1)];
          o.d = '0;
        end else begin
          o.a = AW'($urandom);
          o.d = DW'($urandom);
          wlist.push_back(o.a);
        end
        ops.push_back(o);
      end
      run_ops();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_modport.md
# apb_modport

Self-contained APB subsystem: one APB master bridge plus two APB slave memories. It converts a simple request interface (transfer / READ_WRITE / addresses / write data) into APB SETUP/ACCESS phases. The address MSB routes each access to slave 0 or slave 1, and read data returns on `apb_read_data_out`. It sits at the top of the APB test subsystem, driven directly by the driver-side request signals.

## Interface
- `AW`, default 9: address width; bit `AW-1` selects the slave, bits `AW-2:0` index the slave memory.
- `DW`, default 8: data width.
- `pclk`  in  1: single clock; all logic is rising-edge.
- `presetn`  in  1: reset, asynchronous assert, active-low.
- `transfer`  in  1: request a transaction; sampled every rising edge.
- `READ_WRITE`  in  1: 1 = read, 0 = write.
- `apb_write_paddr`  in  AW: write address.
- `apb_write_data`  in  DW: write data.
- `apb_read_paddr`  in  AW: read address.
- `apb_read_data_out`  out  DW: last completed read data (registered).

## Operation
- Master FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
  - IDLE: go to SETUP when `transfer`=1, otherwise stay.
  - SETUP: always go to ACCESS.
  - ACCESS with PREADY=1: go to SETUP if `transfer`=1 (back-to-back), otherwise IDLE.
  - ACCESS with PREADY=0: stay in ACCESS.
- Request capture: on entering SETUP, latch PWRITE = `~READ_WRITE`. Latch PADDR from `apb_read_paddr` for reads and from `apb_write_paddr` for writes. Latch PWDATA = `apb_write_data`. These values stay stable through SETUP and ACCESS, whatever the inputs do.
- PSEL1 = PADDR[AW-1]==0; PSEL2 = PADDR[AW-1]==1. Exactly one is asserted in SETUP and ACCESS; none in IDLE.
- PENABLE is asserted only in ACCESS.
- Slaves: each holds a 2^(AW-1) x DW memory.
  - Write: commits on the completing ACCESS edge (PSEL & PENABLE & PREADY & PWRITE).
  - Read: PRDATA = mem[PADDR[AW-2:0]] combinationally while selected.
  - Memories are not reset.
- `apb_read_data_out` loads the selected slave's PRDATA on a completing read ACCESS edge. It holds its value at all other times, including across writes and idle cycles.
- Reset values: state IDLE, PSEL1/PSEL2/PENABLE/PWRITE = 0, PADDR/PWDATA = 0, `apb_read_data_out` = 0.
- Reset asserted mid-transaction aborts the transfer: FSM goes to IDLE immediately, no memory write occurs, and outputs return to reset values.

## Timing
- `transfer` sampled high at edge N → SETUP during cycle N→N+1 → ACCESS during N+1→N+2.
- With zero wait states, a write commits at edge N+2. For a read, `apb_read_data_out` is valid after edge N+2 (3-edge latency).
- Back-to-back: with `transfer` held high, each transfer takes 2 cycles (SETUP, ACCESS). New inputs are captured at the ACCESS→SETUP edge.
- `transfer` deasserting during SETUP or ACCESS does not cancel the in-flight transfer.
- A read after a write to the same address returns the new data; no hazard, since the write commits before the next SETUP.

## Configuration
- `APB_WAIT_STATE_EN`:
  - Defined: each slave drives PREADY=0 during the first ACCESS cycle and 1 during the second. Every transfer is then 3 cycles, and read-data latency becomes 4 edges.
  - Undefined: PREADY=1 whenever selected (zero wait states).
- In both builds, the master FSM must honour PREADY.

## Test plan
- Reset: hold `presetn`=0 with arbitrary inputs → `apb_read_data_out`=0, FSM IDLE, PSEL/PENABLE low. Assert `presetn` low during ACCESS of a write to 0x005 → the location is not modified.
- Slave 0 write/read: write 0x3C to 0x012, then read 0x012 → `apb_read_data_out`=0x3C, 3 edges after the read's `transfer` sample.
- Slave 1 routing: write 0xA5 to 0x112 and 0x5A to 0x012, then read both → 0xA5 and 0x5A. Only the matching PSEL is asserted each time.
- Back-to-back: hold `transfer`=1 for 4 writes (0x001..0x004 ← 0x11..0x44), then 4 reads → data 0x11..0x44 in order, each transfer exactly 2 cycles apart.
- Input stability: change `apb_write_data` from 0x77 to 0xFF during SETUP of a write to 0x020 → a read of 0x020 returns 0x77.
- `APB_WAIT_STATE_EN` build: the same write/read of 0x3C at 0x012 → PENABLE high for 2 cycles and the result still 0x3C.
